// File: rtl/axis_block_packer_pkg.sv
// Shared widths for the SHA-256 transmit path: input word size, block beat size and the
// derived number of input words per block.
package axis_block_packer_pkg;

  localparam int unsigned S_DATA_WIDTH_DEFAULT = 64;
  localparam int unsigned M_DATA_WIDTH_DEFAULT = 512;

  function automatic int unsigned slots_for(input int unsigned s_width,
                                            input int unsigned m_width);
    return m_width / s_width;
  endfunction

  localparam int unsigned SLOTS_DEFAULT = slots_for(S_DATA_WIDTH_DEFAULT, M_DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI4-Stream register stage. Accepts a new beat whenever it is empty or its
// current beat is being consumed, and holds data/keep/last stable while stalled.
module axis_reg_slice
  import axis_block_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = M_DATA_WIDTH_DEFAULT,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  last_q;
  logic                  valid_q;
  logic                  load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= in_data;
      keep_q  <= in_keep;
      last_q  <= in_last;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/axis_block_packer.sv
// Packs narrow message words into one-block beats with byte-accurate tkeep and tlast,
// feeding the padder. Assembly register plus output register slice give full-rate input.
module axis_block_packer
  import axis_block_packer_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = S_DATA_WIDTH_DEFAULT,
  parameter int unsigned M_DATA_WIDTH = M_DATA_WIDTH_DEFAULT
) (
  input  logic                      axis_aclk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int unsigned SLOTS   = slots_for(S_DATA_WIDTH, M_DATA_WIDTH);
  localparam int unsigned S_KEEP  = S_DATA_WIDTH / 8;
  localparam int unsigned M_KEEP  = M_DATA_WIDTH / 8;
  localparam int unsigned SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [M_DATA_WIDTH-1:0] asm_data_q, asm_data_d;
  logic [M_KEEP-1:0]       asm_keep_q, asm_keep_d;
  logic                    asm_last_q, asm_last_d;
  // A completed beat is sitting in the assembly register waiting for the output slice.
  logic                    full_q, full_d;

  logic slice_ready;
  logic move;
  logic pending;
  logic accept;
  logic complete;

  assign move     = full_q & slice_ready;
  assign pending  = full_q & ~slice_ready;
  assign s_axis_tready = en & ~reset & ~pending;
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign complete = accept & (s_axis_tlast | (slot_q == LAST_SLOT));

  // A move and an accept can share a cycle: the beat leaves while slot 0 of the next fills.
  always_comb begin
    slot_d     = slot_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    asm_last_d = asm_last_q;
    full_d     = full_q;
    if (move) begin
      asm_data_d = '0;
      asm_keep_d = '0;
      asm_last_d = 1'b0;
      full_d     = 1'b0;
    end
    if (accept) begin
      asm_data_d[int'(slot_q)*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
      asm_keep_d[int'(slot_q)*S_KEEP +: S_KEEP]             = s_axis_tkeep;
      if (complete) begin
        slot_d     = '0;
        full_d     = 1'b1;
        asm_last_d = s_axis_tlast;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      slot_q     <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      asm_last_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      asm_last_q <= asm_last_d;
      full_q     <= full_d;
    end
  end

  axis_reg_slice #(
    .DATA_WIDTH (M_DATA_WIDTH),
    .KEEP_WIDTH (M_KEEP)
  ) u_out_slice (
    .clk       (axis_aclk),
    .reset     (reset),
    .in_data   (asm_data_q),
    .in_keep   (asm_keep_q),
    .in_last   (asm_last_q),
    .in_valid  (full_q),
    .in_ready  (slice_ready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_last  (m_axis_tlast),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_block_packer.sv
// Self-checking bench for axis_block_packer: directed scenarios plus a randomized stress run
// compared against a message-level model of how words map onto block beats.
module tb_axis_block_packer;

  localparam int S     = 64;
  localparam int M     = 512;
  localparam int SK    = S / 8;
  localparam int MK    = M / 8;
  localparam int SLOTS = M / S;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [S-1:0]  s_tdata;
  logic [SK-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [M-1:0]  m_tdata;
  logic [MK-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  int checks   = 0;
  int failures = 0;
  bit abort    = 0;

  logic [M-1:0]  got_data[$];
  logic [MK-1:0] got_keep[$];
  logic          got_last[$];
  logic [M-1:0]  exp_data[$];
  logic [MK-1:0] exp_keep[$];
  logic          exp_last[$];
  logic [S-1:0]  in_d[$];
  logic [SK-1:0] in_k[$];
  logic          in_l[$];

  always #5 clk = ~clk;

  axis_block_packer #(
    .S_DATA_WIDTH (S),
    .M_DATA_WIDTH (M)
  ) dut (
    .axis_aclk     (clk),
    .reset         (reset),
    .en            (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  // Output monitor: record every beat that handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && m_tvalid && m_tready) begin
        got_data.push_back(m_tdata);
        got_keep.push_back(m_tkeep);
        got_last.push_back(m_tlast);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d required=finish", $time);
    $fatal(1);
  end

  // Reference: word i of an n-word message lands in beat i/SLOTS, slot i%SLOTS; only the final
  // beat of the message carries tlast; the last word keeps nb low bytes.
  task automatic model_message(input int n, input int nb);
    int beats;
    logic [M-1:0] d;
    logic [MK-1:0] k;
    logic [S-1:0] w;
    logic [SK-1:0] kw;
    beats = (n + SLOTS - 1) / SLOTS;
    for (int b = 0; b < beats; b++) begin
      d = '0;
      k = '0;
      for (int s = 0; s < SLOTS; s++) begin
        int i;
        i = b * SLOTS + s;
        if (i < n) begin
          w  = {$urandom, $urandom};
          kw = (i == n - 1) ? SK'((1 << nb) - 1) : {SK{1'b1}};
          in_d.push_back(w);
          in_k.push_back(kw);
          in_l.push_back(i == n - 1);
          d[s*S +: S]   = w;
          k[s*SK +: SK] = kw;
        end
      end
      exp_data.push_back(d);
      exp_keep.push_back(k);
      exp_last.push_back(b == beats - 1);
    end
  endtask

  task automatic clear_queues();
    got_data.delete(); got_keep.delete(); got_last.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    in_d.delete(); in_k.delete(); in_l.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_queues();
  endtask

  task automatic send_word(input logic [S-1:0] d, input logic [SK-1:0] k, input logic l);
    bit ok;
    ok = 0;
    if (abort) return;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      abort = 1;
      $display("FAIL input_handshake: got no s_tready within 300 cycles, required s_tready=1 (data=%h)", d);
    end
  endtask

  task automatic drive_inputs();
    while (in_d.size() > 0) send_word(in_d.pop_front(), in_k.pop_front(), in_l.pop_front());
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (got_data.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (got_data.size() < n) begin
      failures++;
      $display("FAIL beat_count_timeout: got %0d beats, required %0d", got_data.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; s_tvalid = 1'b1; s_tdata = '1; s_tkeep = '1; s_tlast = 1'b1;
    m_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b required 0", s_tready); end
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_m_tlast: got %b required 0", m_tlast); end
    if (m_tdata !== '0) begin failures++; $display("FAIL reset_m_tdata: got %h required 0", m_tdata); end
    if (m_tkeep !== '0) begin failures++; $display("FAIL reset_m_tkeep: got %h required 0", m_tkeep); end
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin failures++; $display("FAIL post_reset_s_tready: got %b required 1", s_tready); end
    clear_queues();
  endtask

  task automatic test_full_beat();
    logic [M-1:0] d;
    apply_reset();
    m_tready = 1'b1;
    d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      d[i*S +: S] = S'(i + 1);
      send_word(S'(i + 1), 8'hFF, i == SLOTS - 1);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL full_latency_early: got tvalid=%b required 0", m_tvalid); end
    @(posedge clk);
    #1;
    checks += 4;
    if (m_tvalid !== 1'b1) begin failures++; $display("FAIL full_latency: got tvalid=%b required 1", m_tvalid); end
    if (m_tdata !== d) begin failures++; $display("FAIL full_tdata: got %h required %h", m_tdata, d); end
    if (m_tkeep !== {MK{1'b1}}) begin failures++; $display("FAIL full_tkeep: got %h required all ones", m_tkeep); end
    if (m_tlast !== 1'b1) begin failures++; $display("FAIL full_tlast: got %b required 1", m_tlast); end
  endtask

  task automatic test_partial_last();
    apply_reset();
    m_tready = 1'b1;
    model_message(3, 4);
    drive_inputs();
    wait_beats(1, 20);
    if (got_data.size() >= 1) begin
      checks += 3;
      if (got_keep[0] !== 64'h0000_0000_000F_FFFF) begin
        failures++; $display("FAIL partial_tkeep: got %h required 000fffff", got_keep[0]);
      end
      if (got_data[0][M-1:192] !== '0) begin
        failures++; $display("FAIL partial_upper_zero: got %h required 0", got_data[0][M-1:192]);
      end
      if (got_data[0] !== exp_data[0] || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL partial_beat: got data=%h last=%b required data=%h last=1",
                 got_data[0], got_last[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_tready = 1'b0;
    model_message(16, 8);
    fork
      begin
        drive_inputs();
        checks++;
        if (s_tready !== 1'b0) begin
          failures++; $display("FAIL b2b_backpressure: got s_tready=%b required 0", s_tready);
        end
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (m_tvalid) break;
        end
        repeat (10) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_beats(2, 40);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() !== 2) begin
      failures++; $display("FAIL b2b_beat_count: got %0d required 2", got_data.size());
    end
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                 i, got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic [S-1:0] w;
    apply_reset();
    m_tready = 1'b1;
    w = {$urandom, $urandom};
    en = 1'b0;
    s_tdata = w; s_tkeep = 8'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0) begin failures++; $display("FAIL en_low_s_tready: got %b required 0", s_tready); end
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    send_word(w, 8'hFF, 1'b1);
    wait_beats(1, 10);
    if (got_data.size() >= 1) begin
      checks++;
      if (got_data[0] !== {{(M - S){1'b0}}, w} || got_keep[0] !== 64'hFF || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL en_beat: got data=%h keep=%h last=%b required data=%h keep=ff last=1",
                 got_data[0], got_keep[0], got_last[0], w);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 8'hFF, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (got_data.size() !== 0 || m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_output: got beats=%0d tvalid=%b required 0 and 0", got_data.size(), m_tvalid);
    end
    model_message(2, 8);
    drive_inputs();
    wait_beats(1, 10);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() !== 1) begin
      failures++; $display("FAIL reset_mid_count: got %0d required 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== exp_data[0] || got_keep[0] !== 64'hFFFF || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_beat: got data=%h keep=%h last=%b required data=%h keep=ffff last=1",
                 got_data[0], got_keep[0], got_last[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_random_stress();
    bit stop;
    stop = 0;
    apply_reset();
    for (int m = 0; m < 200; m++) model_message($urandom_range(1, 20), $urandom_range(1, 8));
    fork
      begin
        while (in_d.size() > 0 && !abort) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_word(in_d.pop_front(), in_k.pop_front(), in_l.pop_front());
        end
        wait_beats(exp_data.size(), 2000);
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
      begin
        bit stalled;
        logic [M-1:0] pd;
        logic [MK-1:0] pk;
        logic pl;
        stalled = 0;
        while (!stop) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl) begin
              failures++;
              $display("FAIL stall_hold: got valid=%b keep=%h last=%b required valid=1 keep=%h last=%b",
                       m_tvalid, m_tkeep, m_tlast, pk, pl);
            end
          end
          stalled = m_tvalid && !m_tready;
          pd = m_tdata; pk = m_tkeep; pl = m_tlast;
        end
      end
    join
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      failures++;
      $display("FAIL stress_beat_count: got %0d required %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] || got_last[i] !== exp_last[i]) begin
        failures++;
        $display("FAIL stress_beat%0d: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                 i, got_data[i], got_keep[i], got_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial_last();
    test_back_to_back();
    test_en_toggle();
    test_reset_mid();
    test_random_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
